// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory system between the instruction-fetch
// port and the data port. Round-robin grant, registered launch, combinational
// completion forwarding, and a watchdog that aborts a hung transaction.

// Single-bit-or-wider register with synchronous active-high reset.
module dff #(
  parameter int unsigned  W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d every edge, or the reset value while rst is high.
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// state   | meaning
// IDLE    | nothing in flight; arbitrate pending requests, flag illegal data op
// SERVE_I | fetch in flight at the memory system
// SERVE_D | load or store in flight at the memory system
// DRAIN   | watchdog fired; wait for a late sys_done or 4 cycles
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_rd,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] sys_data_out,
  input  logic        sys_done,
  input  logic        sys_cachehit,
  input  logic        sys_err,
  output logic [15:0] sys_addr,
  output logic [15:0] sys_data_in,
  output logic        sys_rd,
  output logic        sys_wr,
  output logic [15:0] i_data_out,
  output logic        i_done,
  output logic        i_stall,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_hit,
  output logic        err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Watchdog terminal count; TIMEOUT is expected in 4..255.
  localparam logic [7:0] WD_TC      = 8'(TIMEOUT - 1);
  localparam logic [1:0] DRAIN_LAST = 2'd3;

  logic [1:0]  state_q, state_nxt;
  logic        grant_q, grant_nxt;
  logic        last_grant_q, last_grant_nxt;

  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic [7:0]  wd_cnt_q;
  logic [1:0]  drain_cnt_q;
  logic        withdrawn_q;
  logic [15:0] i_data_q;
  logic [15:0] d_data_q;

  logic d_any, d_one, d_bad;
  logic in_idle, serving, draining;
  logic win_i, win_d, illegal;
  logic wd_tc, complete, timeout, txn_end;
  logic req_g, port_ok;
  logic [15:0] ret_data;

  dff #(.W(2), .RST_VAL(IDLE)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d   (state_nxt),
    .q   (state_q)
  );

  dff #(.W(1), .RST_VAL(PORT_I)) u_grant_reg (
    .clk (clk),
    .rst (rst),
    .d   (grant_nxt),
    .q   (grant_q)
  );

  // Reset to the data port so the fetch port wins the first tie.
  dff #(.W(1), .RST_VAL(PORT_D)) u_last_grant_reg (
    .clk (clk),
    .rst (rst),
    .d   (last_grant_nxt),
    .q   (last_grant_q)
  );

  assign d_any = d_rd | d_wr;
  assign d_one = d_rd ^ d_wr;
  assign d_bad = d_rd & d_wr;

  assign in_idle  = (state_q == IDLE);
  assign serving  = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign draining = (state_q == DRAIN);

  // A malformed data request never competes; a pending fetch is served first
  // and the data port is left to be flagged once the arbiter is idle again.
  assign win_i   = in_idle & i_rd & (~d_any | d_bad | (last_grant_q == PORT_D));
  assign win_d   = in_idle & d_one & (~i_rd | (last_grant_q == PORT_I));
  assign illegal = in_idle & d_bad & ~i_rd & ~rst;

  assign wd_tc    = (wd_cnt_q == WD_TC);
  assign complete = serving & sys_done;
  assign timeout  = serving & ~sys_done & wd_tc;
  assign txn_end  = complete | timeout;

  // A requester that let go at any point during its transaction gets no done.
  assign req_g    = (grant_q == PORT_D) ? d_any : i_rd;
  assign port_ok  = req_g & ~withdrawn_q & ~rst;
  assign ret_data = complete ? sys_data_out : 16'h0000;

  // Next-state and grant bookkeeping.
  always_comb begin
    state_nxt      = state_q;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant_q;
    case (state_q)
      IDLE: begin
        if (win_i) begin
          state_nxt      = SERVE_I;
          grant_nxt      = PORT_I;
          last_grant_nxt = PORT_I;
        end else if (win_d) begin
          state_nxt      = SERVE_D;
          grant_nxt      = PORT_D;
          last_grant_nxt = PORT_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (sys_done)   state_nxt = IDLE;
        else if (wd_tc) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (sys_done || (drain_cnt_q == DRAIN_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Launch capture, watchdog and drain counters, withdraw tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wd_cnt_q    <= '0;
      drain_cnt_q <= '0;
      withdrawn_q <= 1'b0;
    end else begin
      if (win_i | win_d) begin
        addr_q      <= win_i ? i_addr : d_addr;
        wdata_q     <= win_d ? d_data_in : 16'h0000;
        rd_q        <= win_i | (win_d & d_rd);
        wr_q        <= win_d & d_wr;
        wd_cnt_q    <= '0;
        withdrawn_q <= 1'b0;
      end else if (serving) begin
        if (!wd_tc) wd_cnt_q <= wd_cnt_q + 8'd1;
        if (!req_g) withdrawn_q <= 1'b1;
      end
      drain_cnt_q <= draining ? drain_cnt_q + 2'd1 : 2'd0;
    end
  end

  // Hold the last returned data of each port between completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_data_q <= '0;
      d_data_q <= '0;
    end else begin
      i_data_q <= i_data_out;
      d_data_q <= d_data_out;
    end
  end

  // Memory-side command, requester-side completion, stall and error outputs.
  always_comb begin
    sys_addr    = addr_q;
    sys_data_in = wdata_q;
    sys_rd      = serving & rd_q & ~txn_end & ~rst;
    sys_wr      = serving & wr_q & ~txn_end & ~rst;
    i_done      = 1'b0;
    d_done      = 1'b0;
    i_data_out  = i_data_q;
    d_data_out  = d_data_q;
    d_hit       = 1'b0;
    err         = 1'b0;
    if (txn_end & port_ok) begin
      if (grant_q == PORT_I) begin
        i_done     = 1'b1;
        i_data_out = ret_data;
      end else begin
        d_done     = 1'b1;
        d_data_out = ret_data;
        d_hit      = complete & sys_cachehit;
      end
    end
    if (illegal) begin
      d_done     = 1'b1;
      d_data_out = 16'h0000;
    end
    if (!rst) err = illegal | timeout | (complete & sys_err);
    i_stall = i_rd & ~i_done & ~rst;
    d_stall = d_any & ~d_done & ~rst;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized single
// transactions, checked against timeline expectations built from the rules.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr, d_addr, d_data_in, sys_data_out;
  logic        i_rd, d_rd, d_wr, sys_done, sys_cachehit, sys_err;
  logic [15:0] sys_addr, sys_data_in, i_data_out, d_data_out;
  logic        sys_rd, sys_wr, i_done, i_stall, d_done, d_stall, d_hit, err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_i_data, exp_d_data;
  bit last_d;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rd(i_rd),
    .d_addr(d_addr), .d_data_in(d_data_in), .d_rd(d_rd), .d_wr(d_wr),
    .sys_data_out(sys_data_out), .sys_done(sys_done),
    .sys_cachehit(sys_cachehit), .sys_err(sys_err),
    .sys_addr(sys_addr), .sys_data_in(sys_data_in),
    .sys_rd(sys_rd), .sys_wr(sys_wr),
    .i_data_out(i_data_out), .i_done(i_done), .i_stall(i_stall),
    .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall),
    .d_hit(d_hit), .err(err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_rd = 0; d_rd = 0; d_wr = 0;
    sys_done = 0; sys_err = 0; sys_cachehit = 0; sys_data_out = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    i_addr = 16'hFFFF; d_addr = 16'hEEEE; d_data_in = 16'hDDDD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (sys_rd !== 1'b0 || sys_wr !== 1'b0) begin errors++; $display("FAIL reset_cmd: rd=%b wr=%b want 0 0", sys_rd, sys_wr); end
    checks++; if (sys_addr !== 16'h0 || sys_data_in !== 16'h0) begin errors++; $display("FAIL reset_sys_bus: addr=%h data=%h want 0", sys_addr, sys_data_in); end
    checks++; if (i_data_out !== 16'h0 || d_data_out !== 16'h0) begin errors++; $display("FAIL reset_data: i=%h d=%h want 0", i_data_out, d_data_out); end
    checks++; if ({i_done, d_done, i_stall, d_stall, d_hit, err} !== 6'b0) begin errors++; $display("FAIL reset_flags: %b want 000000", {i_done, d_done, i_stall, d_stall, d_hit, err}); end
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    checks++; if (sys_rd !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_release: rd=%b err=%b want 0 0", sys_rd, err); end
    exp_i_data = '0; exp_d_data = '0; last_d = 1'b1;
  endtask

  task automatic test_single_fetch();
    bit fin;
    @(posedge clk); #1; i_rd = 1; i_addr = 16'h0010;
    @(negedge clk);
    checks++; if (sys_rd !== 1'b0) begin errors++; $display("FAIL fetch_arb_latency: sys_rd=%b want 0", sys_rd); end
    checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall0: i_stall=%b want 1", i_stall); end
    for (int c = 1; c <= 3; c++) begin
      fin = (c == 3);
      @(posedge clk); #1;
      sys_done = fin; sys_data_out = fin ? 16'hABCD : 16'h5555;
      @(negedge clk);
      checks++; if (sys_rd !== ~fin) begin errors++; $display("FAIL fetch_rd c%0d: sys_rd=%b want %b", c, sys_rd, ~fin); end
      checks++; if (sys_addr !== 16'h0010) begin errors++; $display("FAIL fetch_addr c%0d: %h want 0010", c, sys_addr); end
      checks++; if (i_done !== fin || i_stall !== ~fin) begin errors++; $display("FAIL fetch_done c%0d: done=%b stall=%b want %b %b", c, i_done, i_stall, fin, ~fin); end
      if (fin) begin
        checks++; if (i_data_out !== 16'hABCD) begin errors++; $display("FAIL fetch_data: %h want abcd", i_data_out); end
      end
    end
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    checks++; if (i_data_out !== 16'hABCD || i_done !== 1'b0 || i_stall !== 1'b0) begin errors++; $display("FAIL fetch_hold: data=%h done=%b stall=%b want abcd 0 0", i_data_out, i_done, i_stall); end
    exp_i_data = 16'hABCD; last_d = 1'b0;
  endtask

  task automatic test_random_txn();
    for (int n = 0; n < 12; n++) begin
      bit port_d, is_wr, hit, serr, fin, exp_rd, exp_wr;
      logic [15:0] a, wd, rdv;
      int lat;
      port_d = 1'($urandom_range(0, 1));
      is_wr  = port_d & 1'($urandom_range(0, 1));
      hit    = 1'($urandom_range(0, 1));
      serr   = ($urandom_range(0, 3) == 0);
      a = 16'($urandom); wd = 16'($urandom); rdv = 16'($urandom);
      lat = $urandom_range(1, 6);
      @(posedge clk); #1;
      i_rd = ~port_d; d_rd = port_d & ~is_wr; d_wr = port_d & is_wr;
      i_addr = port_d ? 16'($urandom) : a;
      d_addr = port_d ? a : 16'($urandom);
      d_data_in = wd;
      @(negedge clk);
      checks++; if (sys_rd !== 1'b0 || sys_wr !== 1'b0) begin errors++; $display("FAIL rnd_early n%0d: rd=%b wr=%b want 0 0", n, sys_rd, sys_wr); end
      for (int c = 1; c <= lat; c++) begin
        fin = (c == lat);
        @(posedge clk); #1;
        i_addr = 16'($urandom); d_addr = 16'($urandom); d_data_in = 16'($urandom);
        sys_done = fin; sys_err = fin & serr; sys_cachehit = hit;
        sys_data_out = fin ? rdv : 16'($urandom);
        @(negedge clk);
        exp_rd = ~fin & ~is_wr;
        exp_wr = ~fin & is_wr;
        checks++; if (sys_rd !== exp_rd || sys_wr !== exp_wr) begin errors++; $display("FAIL rnd_cmd n%0d c%0d: rd=%b wr=%b want %b %b", n, c, sys_rd, sys_wr, exp_rd, exp_wr); end
        checks++; if (sys_addr !== a) begin errors++; $display("FAIL rnd_addr n%0d c%0d: %h want %h", n, c, sys_addr, a); end
        if (is_wr) begin
          checks++; if (sys_data_in !== wd) begin errors++; $display("FAIL rnd_wdata n%0d c%0d: %h want %h", n, c, sys_data_in, wd); end
        end
        checks++; if (i_done !== (fin & ~port_d) || d_done !== (fin & port_d)) begin errors++; $display("FAIL rnd_done n%0d c%0d: i=%b d=%b want %b %b", n, c, i_done, d_done, fin & ~port_d, fin & port_d); end
        checks++; if (i_stall !== (~fin & ~port_d) || d_stall !== (~fin & port_d)) begin errors++; $display("FAIL rnd_stall n%0d c%0d: i=%b d=%b want %b %b", n, c, i_stall, d_stall, ~fin & ~port_d, ~fin & port_d); end
        checks++; if (err !== (fin & serr)) begin errors++; $display("FAIL rnd_err n%0d c%0d: %b want %b", n, c, err, fin & serr); end
        checks++; if (d_hit !== (fin & port_d & hit)) begin errors++; $display("FAIL rnd_hit n%0d c%0d: %b want %b", n, c, d_hit, fin & port_d & hit); end
        if (fin) begin
          if (port_d) exp_d_data = rdv; else exp_i_data = rdv;
        end
        checks++; if (i_data_out !== exp_i_data || d_data_out !== exp_d_data) begin errors++; $display("FAIL rnd_data n%0d c%0d: i=%h d=%h want %h %h", n, c, i_data_out, d_data_out, exp_i_data, exp_d_data); end
      end
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      checks++; if (i_data_out !== exp_i_data || d_data_out !== exp_d_data || i_done !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL rnd_hold n%0d: i=%h d=%h want %h %h", n, i_data_out, d_data_out, exp_i_data, exp_d_data); end
      last_d = port_d;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ia, da;
    ia = 16'($urandom); da = 16'($urandom);
    @(posedge clk); #1; rst = 1; idle_inputs();
    @(posedge clk); #1; rst = 0;
    exp_i_data = '0; exp_d_data = '0; last_d = 1'b1;
    i_rd = 1; d_rd = 1; i_addr = ia; d_addr = da;
    for (int k = 0; k < 4; k++) begin
      bit pd, fin;
      logic [15:0] rdv;
      int lat;
      pd  = ~last_d;
      rdv = 16'($urandom);
      lat = $urandom_range(1, 5);
      if (k > 0) begin @(posedge clk); #1; sys_done = 0; end
      @(negedge clk);
      checks++; if (sys_rd !== 1'b0 || i_stall !== 1'b1 || d_stall !== 1'b1) begin errors++; $display("FAIL b2b_gap k%0d: rd=%b istall=%b dstall=%b want 0 1 1", k, sys_rd, i_stall, d_stall); end
      for (int c = 1; c <= lat; c++) begin
        fin = (c == lat);
        @(posedge clk); #1;
        sys_done = fin; sys_data_out = fin ? rdv : 16'($urandom);
        @(negedge clk);
        checks++; if (sys_addr !== (pd ? da : ia)) begin errors++; $display("FAIL b2b_addr k%0d c%0d: %h want %h", k, c, sys_addr, pd ? da : ia); end
        checks++; if (sys_rd !== ~fin) begin errors++; $display("FAIL b2b_rd k%0d c%0d: %b want %b", k, c, sys_rd, ~fin); end
        checks++; if (i_done !== (fin & ~pd) || d_done !== (fin & pd)) begin errors++; $display("FAIL b2b_done k%0d c%0d: i=%b d=%b want %b %b", k, c, i_done, d_done, fin & ~pd, fin & pd); end
        checks++; if ((pd ? i_stall : d_stall) !== 1'b1) begin errors++; $display("FAIL b2b_other_stall k%0d c%0d: got 0 want 1", k, c); end
        if (fin) begin
          if (pd) exp_d_data = rdv; else exp_i_data = rdv;
          checks++; if (i_data_out !== exp_i_data || d_data_out !== exp_d_data) begin errors++; $display("FAIL b2b_data k%0d: i=%h d=%h want %h %h", k, i_data_out, d_data_out, exp_i_data, exp_d_data); end
        end
      end
      last_d = pd;
    end
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    checks++; if (i_stall !== 1'b0 || d_stall !== 1'b0 || sys_rd !== 1'b0) begin errors++; $display("FAIL b2b_end: istall=%b dstall=%b rd=%b want 0 0 0", i_stall, d_stall, sys_rd); end
  endtask

  task automatic test_capture();
    int done_cnt;
    bit fin;
    logic [15:0] rdv;
    done_cnt = 0; rdv = 16'($urandom);
    @(posedge clk); #1; d_wr = 1; d_addr = 16'h0100; d_data_in = 16'h1234;
    @(negedge clk);
    if (d_done === 1'b1) done_cnt++;
    for (int c = 1; c <= 4; c++) begin
      fin = (c == 4);
      @(posedge clk); #1;
      if (c == 2) begin d_addr = 16'h0200; d_data_in = 16'h9999; end
      sys_done = fin; sys_data_out = fin ? rdv : 16'h0;
      @(negedge clk);
      if (d_done === 1'b1) done_cnt++;
      checks++; if (sys_addr !== 16'h0100 || sys_data_in !== 16'h1234) begin errors++; $display("FAIL cap_bus c%0d: addr=%h data=%h want 0100 1234", c, sys_addr, sys_data_in); end
      checks++; if (sys_wr !== ~fin || sys_rd !== 1'b0) begin errors++; $display("FAIL cap_cmd c%0d: wr=%b rd=%b want %b 0", c, sys_wr, sys_rd, ~fin); end
    end
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    if (d_done === 1'b1) done_cnt++;
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL cap_done_count: %0d want 1", done_cnt); end
    exp_d_data = rdv; last_d = 1'b1;
  endtask

  task automatic test_illegal();
    @(posedge clk); #1; d_rd = 1; d_wr = 1; d_addr = 16'h0400;
    @(negedge clk);
    checks++; if (sys_rd !== 1'b0 || sys_wr !== 1'b0) begin errors++; $display("FAIL ill_launch: rd=%b wr=%b want 0 0", sys_rd, sys_wr); end
    checks++; if (err !== 1'b1 || d_done !== 1'b1) begin errors++; $display("FAIL ill_pulse: err=%b done=%b want 1 1", err, d_done); end
    checks++; if (d_data_out !== 16'h0) begin errors++; $display("FAIL ill_data: %h want 0000", d_data_out); end
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    checks++; if (err !== 1'b0 || d_done !== 1'b0 || d_data_out !== 16'h0) begin errors++; $display("FAIL ill_after: err=%b done=%b data=%h want 0 0 0000", err, d_done, d_data_out); end
    exp_d_data = '0;
  endtask

  task automatic test_timeout();
    logic [15:0] a, da, rdv;
    a = 16'($urandom); da = 16'($urandom); rdv = 16'($urandom);
    @(posedge clk); #1; i_rd = 1; i_addr = a;
    @(negedge clk);
    checks++; if (sys_rd !== 1'b0) begin errors++; $display("FAIL to_arb: sys_rd=%b want 0", sys_rd); end
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 9) begin i_rd = 0; d_rd = 1; d_addr = da; end
      sys_done = (c == 15); sys_data_out = (c == 15) ? rdv : 16'($urandom);
      @(negedge clk);
      if (c <= TO) begin
        checks++; if (sys_rd !== (c < TO) || sys_addr !== a) begin errors++; $display("FAIL to_cmd c%0d: rd=%b addr=%h want %b %h", c, sys_rd, sys_addr, c < TO, a); end
        checks++; if (i_done !== (c == TO) || err !== (c == TO)) begin errors++; $display("FAIL to_pulse c%0d: done=%b err=%b want %b %b", c, i_done, err, c == TO, c == TO); end
        if (c == TO) begin
          checks++; if (i_data_out !== 16'h0) begin errors++; $display("FAIL to_data: %h want 0000", i_data_out); end
        end
      end else if (c <= 13) begin
        checks++; if (sys_rd !== 1'b0 || err !== 1'b0 || d_done !== 1'b0 || d_stall !== 1'b1) begin errors++; $display("FAIL to_drain c%0d: rd=%b err=%b done=%b stall=%b want 0 0 0 1", c, sys_rd, err, d_done, d_stall); end
      end else if (c == 14) begin
        checks++; if (sys_rd !== 1'b1 || sys_addr !== da) begin errors++; $display("FAIL to_relaunch: rd=%b addr=%h want 1 %h", sys_rd, sys_addr, da); end
      end else begin
        checks++; if (d_done !== 1'b1 || d_data_out !== rdv || i_data_out !== 16'h0) begin errors++; $display("FAIL to_next_done: done=%b d=%h i=%h want 1 %h 0000", d_done, d_data_out, i_data_out, rdv); end
      end
    end
    @(posedge clk); #1; idle_inputs();
    exp_i_data = '0; exp_d_data = rdv; last_d = 1'b1;
  endtask

  task automatic test_withdraw();
    logic [15:0] a, b, rdv, rdv2;
    a = 16'($urandom); b = 16'($urandom); rdv = 16'($urandom); rdv2 = 16'($urandom);
    @(posedge clk); #1; i_rd = 1; i_addr = a;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 2) i_rd = 0;
      if (c == 5) begin d_rd = 1; d_addr = b; end
      sys_done = (c == 4) || (c == 7);
      sys_data_out = (c == 4) ? rdv : rdv2;
      @(negedge clk);
      if (c <= 3) begin
        checks++; if (sys_rd !== 1'b1 || i_done !== 1'b0) begin errors++; $display("FAIL wd_busy c%0d: rd=%b done=%b want 1 0", c, sys_rd, i_done); end
      end else if (c == 4) begin
        checks++; if (i_done !== 1'b0 || i_data_out !== exp_i_data || sys_rd !== 1'b0) begin errors++; $display("FAIL wd_suppress: done=%b data=%h rd=%b want 0 %h 0", i_done, i_data_out, sys_rd, exp_i_data); end
      end else if (c == 5) begin
        checks++; if (sys_rd !== 1'b0) begin errors++; $display("FAIL wd_idle: rd=%b want 0", sys_rd); end
      end else if (c == 6) begin
        checks++; if (sys_rd !== 1'b1 || sys_addr !== b) begin errors++; $display("FAIL wd_next_launch: rd=%b addr=%h want 1 %h", sys_rd, sys_addr, b); end
      end else begin
        checks++; if (d_done !== 1'b1 || d_data_out !== rdv2) begin errors++; $display("FAIL wd_next_done: done=%b data=%h want 1 %h", d_done, d_data_out, rdv2); end
      end
    end
    @(posedge clk); #1; idle_inputs();
    exp_d_data = rdv2; last_d = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] ia, da, rdv;
    ia = 16'($urandom); da = 16'($urandom); rdv = 16'($urandom);
    @(posedge clk); #1; d_rd = 1; d_addr = da;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (sys_rd !== 1'b1) begin errors++; $display("FAIL rm_serve c%0d: rd=%b want 1", c, sys_rd); end
    end
    @(posedge clk); #1; rst = 1; sys_done = 1; sys_data_out = rdv;
    @(negedge clk);
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL rm_no_done: d_done=%b want 0", d_done); end
    @(posedge clk); #1; rst = 0; idle_inputs();
    @(negedge clk);
    checks++; if (sys_addr !== 16'h0 || sys_data_in !== 16'h0 || sys_rd !== 1'b0 || sys_wr !== 1'b0) begin errors++; $display("FAIL rm_sys_zero: addr=%h data=%h rd=%b wr=%b want 0", sys_addr, sys_data_in, sys_rd, sys_wr); end
    checks++; if (i_data_out !== 16'h0 || d_data_out !== 16'h0) begin errors++; $display("FAIL rm_data_zero: i=%h d=%h want 0", i_data_out, d_data_out); end
    checks++; if ({i_done, d_done, i_stall, d_stall, d_hit, err} !== 6'b0) begin errors++; $display("FAIL rm_flags_zero: %b want 000000", {i_done, d_done, i_stall, d_stall, d_hit, err}); end
    @(posedge clk); #1; i_rd = 1; d_rd = 1; i_addr = ia; d_addr = da;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (sys_rd !== 1'b1 || sys_addr !== ia || d_stall !== 1'b1) begin errors++; $display("FAIL rm_first_tie: rd=%b addr=%h dstall=%b want 1 %h 1", sys_rd, sys_addr, d_stall, ia); end
    @(posedge clk); #1; sys_done = 1; sys_data_out = rdv;
    @(negedge clk);
    checks++; if (i_done !== 1'b1 || d_done !== 1'b0 || i_data_out !== rdv) begin errors++; $display("FAIL rm_tie_done: i=%b d=%b data=%h want 1 0 %h", i_done, d_done, i_data_out, rdv); end
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_random_txn();
    test_back_to_back();
    test_capture();
    test_illegal();
    test_timeout();
    test_withdraw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory system (cache FSM plus banked memory) between the instruction-fetch port and the data-memory port of the pipelined processor.
- Grants one requester at a time with round-robin priority and drives that requester's address, data and command into the memory system.
- Returns data, done and error to the granted requester, and asserts stall to any requester that is waiting.
- Includes a transaction watchdog so that a hung memory system cannot deadlock the pipeline.

Parameters:
- TIMEOUT, 64: maximum number of cycles from launch to sys_done before the arbiter aborts and flags an error. Legal range 4..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_addr  in  16  instruction fetch address.
- i_rd  in  1  instruction read request; held by the fetch stage until i_done.
- d_addr  in  16  data address.
- d_data_in  in  16  store data.
- d_rd  in  1  load request; held until d_done.
- d_wr  in  1  store request; held until d_done.
- sys_data_out  in  16  read data from the memory system.
- sys_done  in  1  one-cycle completion pulse from the memory system.
- sys_cachehit  in  1  completion was a cache hit.
- sys_err  in  1  memory system error.
- sys_addr  out  16  address to the memory system.
- sys_data_in  out  16  write data to the memory system.
- sys_rd  out  1  read command.
- sys_wr  out  1  write command.
- i_data_out  out  16  fetched instruction.
- i_done  out  1  fetch complete.
- i_stall  out  1  fetch port must hold.
- d_data_out  out  16  load data.
- d_done  out  1  data access complete.
- d_stall  out  1  data port must hold.
- d_hit  out  1  data access hit in cache (for performance counters).
- err  out  1  one-cycle error pulse.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, DRAIN. State, grant and last_grant are held in dff instances clocked by clk with synchronous rst.
- Reset values:
  - State is IDLE. last_grant = D, so the instruction port wins the first tie.
  - All outputs are 0: sys_* = 0, *_data_out = 16'h0000, done/stall/err/d_hit = 0. Watchdog counter = 0.
- Reset mid-transaction: the arbiter returns to IDLE on the next edge. No done is forwarded. The memory system is reset by the same rst.
- Arbitration in IDLE, decided combinationally and registered:
  - Only i_rd pending: go to SERVE_I.
  - Only d_rd or d_wr pending: go to SERVE_D.
  - Both pending: grant the port that is not last_grant.
  - last_grant updates on every grant.
- Illegal data request: d_rd and d_wr both high in IDLE with no instruction request. There is no launch. err pulses for 1 cycle, d_done pulses with d_data_out = 0, and the state stays IDLE.
- Launch latency: the request is sampled in IDLE; sys_rd or sys_wr asserts on the first cycle of SERVE_x. This gives one cycle of arbitration latency.
- During SERVE_x:
  - sys_addr, sys_data_in, sys_rd and sys_wr come from registered copies captured at grant. They stay stable even if the requester's inputs change.
  - sys_rd/sys_wr stay asserted until the cycle sys_done is seen, then drop in that same cycle (combinational gate on sys_done).
- Completion, on a cycle with sys_done=1 in SERVE_x:
  - The granted port's done pulses for exactly 1 cycle, combinationally in the same cycle.
  - Its *_data_out = sys_data_out in that cycle and holds the value afterwards until the next completion.
  - d_hit = sys_cachehit on d_done cycles, otherwise 0.
  - Next state is IDLE.
  - If sys_err=1 in the same cycle, err also pulses.
- Requester withdraws (request deasserted before sys_done): the transaction cannot be cancelled. The arbiter finishes it with the memory system, suppresses the port's done, discards the data, and returns to IDLE.
- Stall outputs:
  - i_stall = i_rd & ~i_done.
  - d_stall = (d_rd | d_wr) & ~d_done.
  - The non-granted port therefore stays stalled for the whole other transaction.
- Watchdog:
  - Counter clears at launch and increments each SERVE_x cycle.
  - When it reaches TIMEOUT-1 without sys_done: err pulses, the granted port receives done with data 0, and sys_rd/sys_wr drop.
  - State goes to DRAIN. DRAIN waits for sys_done (discarded), or 4 cycles, whichever comes first, then goes to IDLE.
- Simultaneous new request on the done cycle: it is not granted that cycle. It is re-arbitrated in IDLE on the next cycle. Minimum spacing between two launches is therefore 2 cycles.
- Widths: 16-bit address/data passthrough with no arithmetic. The watchdog counter is 8 bits and saturates at TIMEOUT-1.

Test Plan:
- Reset, then i_rd=1, i_addr=16'h0010; memory returns 16'hABCD with sys_done at cycle 3 after launch -> sys_rd=1 from cycle 1; i_done=1 and i_data_out=16'hABCD on the sys_done cycle; i_stall=1 until then, then 0.
- i_rd and d_rd both held continuously from reset -> grant order I, D, I, D; sys_addr alternates i_addr/d_addr; each port completes every other transaction.
- d_wr=1, d_addr=16'h0100, d_data_in=16'h1234, and d_addr changed to 16'h0200 mid-transaction -> sys_addr stays 16'h0100 and sys_data_in stays 16'h1234 until sys_done; d_done pulses once.
- d_rd=d_wr=1 with i_rd=0 -> no sys_rd/sys_wr; err and d_done each pulse exactly 1 cycle; d_data_out=0.
- TIMEOUT=8 with sys_done held low -> err and i_done pulse at cycle 8 after launch; i_data_out=0; state enters DRAIN, then IDLE 4 cycles later; a subsequent request launches normally.
- rst asserted 2 cycles into SERVE_D -> next cycle all outputs 0 and no d_done; after reset the first tie grants I.
